// File: rtl/overlay_upload.sv
// Serves overlay bytes from SDRAM to the HPS upload handshake.
// A one-dword line buffer absorbs sequential reads, so each SDRAM fetch covers four bytes.
module overlay_upload #(
    parameter int OVL_BYTES = 777600,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    localparam int              TW          = $clog2(TIMEOUT + 1);
    localparam logic [24:0]     OVL_LIMIT   = 25'(OVL_BYTES);
    localparam logic [TW-1:0]   TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [24:0]    r_addr;
    logic [31:0]    r_buf;
    logic [22:0]    r_tag;
    logic           r_bufValid;
    logic [7:0]     r_din;
    logic           r_wait;
    logic           r_err;
    logic           r_uploadD;
    logic [TW-1:0]  r_timer;

    logic           w_rdValid;
    logic           w_outOfRange;
    logic           w_hit;
    logic           w_miss;
    logic           w_timeout;
    logic [TW-1:0]  w_timerNext;

    assign w_rdValid    = ioctl_upload && ioctl_rd && (r_state == S_IDLE);
    assign w_outOfRange = (ioctl_addr >= OVL_LIMIT);
    assign w_hit        = r_bufValid && (r_tag == ioctl_addr[24:2]);
    assign w_miss       = w_rdValid && !w_outOfRange && !w_hit;
    assign w_timerNext  = r_timer + TW'(1);
    assign w_timeout    = (r_state == S_WAIT) && !mem_ack && (w_timerNext == TIMEOUT_CNT);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_nextState = S_REQ;
            S_REQ:   w_nextState = S_WAIT;
            S_WAIT:  if (mem_ack || w_timeout) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Wait is raised combinationally on the miss cycle so the host never samples a stale byte.
    always_comb begin
        mem_req    = (r_state == S_REQ);
        ioctl_wait = r_wait || w_miss;
        busy       = ioctl_upload || (r_state != S_IDLE);
    end

    assign mem_addr  = {r_addr[24:2], 1'b0};
    assign ioctl_din = r_din;
    assign err       = r_err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_addr     <= '0;
            r_buf      <= '0;
            r_tag      <= '0;
            r_bufValid <= 1'b0;
            r_din      <= 8'h00;
            r_wait     <= 1'b0;
            r_err      <= 1'b0;
            r_uploadD  <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_uploadD <= ioctl_upload;
            case (r_state)
                S_IDLE: begin
                    if (w_rdValid) begin
                        if (w_outOfRange) begin
                            r_din <= 8'h00;
                        end else if (w_hit) begin
                            r_din <= r_buf[{ioctl_addr[1:0], 3'b000} +: 8];
                        end else begin
                            r_addr <= ioctl_addr;
                            r_wait <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_buf      <= mem_dout;
                        r_tag      <= r_addr[24:2];
                        r_bufValid <= 1'b1;
                        r_din      <= mem_dout[{r_addr[1:0], 3'b000} +: 8];
                        r_wait     <= 1'b0;
                    end else if (w_timeout) begin
                        r_din      <= 8'hFF;
                        r_err      <= 1'b1;
                        r_wait     <= 1'b0;
                        r_bufValid <= 1'b0;
                    end else begin
                        r_timer <= w_timerNext;
                    end
                end
                default: ;
            endcase
            // Session edges: a new session must refetch, and starts with a clean error flag.
            if (r_uploadD && !ioctl_upload) r_bufValid <= 1'b0;
            if (!r_uploadD && ioctl_upload) r_err <= 1'b0;
        end
    end

endmodule
